// File: rtl/seq_pkg.sv
// Shared types and helpers for the Gray-code sequencer: direction enum,
// per-width maximum, and binary/Gray conversions sized for the widest instance.
package seq_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic {
    DIR_REV = 1'b0,
    DIR_FWD = 1'b1
  } dir_e;

  // All-ones value for a w-bit state, zero-extended to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] max_of(input int w);
    return MAX_WIDTH'((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] w);
    return w ^ (w >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] w);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = w[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ w[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_core.sv
// Combinational next-state for the sequencer: clear/enable priority,
// direction-dependent step, wrap or saturate at the ends, and the boundary event.
module gray_step_core
  import seq_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int WRAP  = 1
) (
  input  logic [WIDTH-1:0] bin,
  input  logic             en,
  input  logic             clr,
  input  logic             c,
  output logic [WIDTH-1:0] bin_n,
  output logic             tc_n
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));

  dir_e dir;
  assign dir = dir_e'(c);

  // The boundary event is the same condition in both modes: a step attempted
  // from the end in the direction of travel. WRAP only picks where it lands.
  always_comb begin
    bin_n = bin;
    tc_n  = 1'b0;
    if (clr) begin
      bin_n = '0;
    end else if (en) begin
      if (dir == DIR_FWD) begin
        if (bin == MAX) begin
          tc_n  = 1'b1;
          bin_n = (WRAP != 0) ? '0 : MAX;
        end else begin
          bin_n = bin + WIDTH'(1);
        end
      end else begin
        if (bin == '0) begin
          tc_n  = 1'b1;
          bin_n = (WRAP != 0) ? MAX : '0;
        end else begin
          bin_n = bin - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gray_seq_circuit.sv
// Parametrised Gray-code sequencer: registered binary and Gray state,
// threshold flag Y and one-cycle boundary pulse tc.
module gray_seq_circuit
  import seq_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             C,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] state_gray,
  output logic [WIDTH-1:0] state_bin,
  output logic             Y,
  output logic             tc
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_n;
  logic [WIDTH-1:0] gray_q;
  logic             tc_n;
  logic             y_q;
  logic             tc_q;

  gray_step_core #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_core (
    .bin   (bin),
    .en    (en),
    .clr   (clr),
    .c     (C),
    .bin_n (bin_n),
    .tc_n  (tc_n)
  );

  // Gray and Y are computed from bin_n so they change together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin    <= '0;
      gray_q <= '0;
      y_q    <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      bin    <= bin_n;
      gray_q <= WIDTH'(bin2gray(MAX_WIDTH'(bin_n)));
      y_q    <= (bin_n >= thresh);
      tc_q   <= tc_n;
    end
  end

  assign state_bin  = bin;
  assign state_gray = gray_q;
  assign Y          = y_q;
  assign tc         = tc_q;

endmodule

// File: tb/tb_gray_seq_circuit.sv
// Self-checking bench: directed scenarios plus randomized stimulus against a
// plain-arithmetic reference model, on three configurations side by side.
module tb_gray_seq_circuit;
  import seq_pkg::*;

  logic clk, rst;
  int checks = 0;
  int errors = 0;

  logic       en2, clr2, c2;
  logic [1:0] th2, g2, b2;
  logic       y2, tc2;
  logic       en3, clr3, c3;
  logic [2:0] th3, g3, b3;
  logic       y3, tc3;
  logic       en4, clr4, c4;
  logic [3:0] th4, g4, b4;
  logic       y4, tc4;

  gray_seq_circuit #(.WIDTH(2), .WRAP(1)) u2 (
    .clk(clk), .rst(rst), .en(en2), .clr(clr2), .C(c2), .thresh(th2),
    .state_gray(g2), .state_bin(b2), .Y(y2), .tc(tc2));
  gray_seq_circuit #(.WIDTH(3), .WRAP(0)) u3 (
    .clk(clk), .rst(rst), .en(en3), .clr(clr3), .C(c3), .thresh(th3),
    .state_gray(g3), .state_bin(b3), .Y(y3), .tc(tc3));
  gray_seq_circuit #(.WIDTH(4), .WRAP(1)) u4 (
    .clk(clk), .rst(rst), .en(en4), .clr(clr4), .C(c4), .thresh(th4),
    .state_gray(g4), .state_bin(b4), .Y(y4), .tc(tc4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference step: plain integer arithmetic on the unbounded value, then fold.
  function automatic void ref_step(input int w, input int wrap, input int s,
                                   input int en, input int clr, input int c,
                                   output int s_n, output int tc_n);
    int m, t;
    m = 1 << w;
    tc_n = 0;
    if (clr != 0) s_n = 0;
    else if (en == 0) s_n = s;
    else begin
      t = (c != 0) ? s + 1 : s - 1;
      if (t < 0 || t >= m) begin
        tc_n = 1;
        s_n = (wrap != 0) ? (t + m) % m : s;
      end else s_n = t;
    end
  endfunction

  task automatic idle_all();
    en2 = 0; clr2 = 0; c2 = 0; th2 = 0;
    en3 = 0; clr3 = 0; c3 = 0; th3 = 0;
    en4 = 0; clr4 = 0; c4 = 0; th4 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    #2;
    rst = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_all();
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++;
    if ({g2, b2, y2, tc2} !== 6'd0) begin
      errors++; $display("FAIL reset_w2: got g=%b b=%b y=%b tc=%b want all 0", g2, b2, y2, tc2);
    end
    checks++;
    if ({g3, b3, y3, tc3} !== 8'd0) begin
      errors++; $display("FAIL reset_w3: got g=%b b=%b y=%b tc=%b want all 0", g3, b3, y3, tc3);
    end
    checks++;
    if ({g4, b4, y4, tc4} !== 10'd0) begin
      errors++; $display("FAIL reset_w4: got g=%b b=%b y=%b tc=%b want all 0", g4, b4, y4, tc4);
    end
    #2;
    rst = 0;
    tick();
    checks++;
    if ({y2, y3, y4} !== 3'b111) begin
      errors++; $display("FAIL thresh0_y: got y=%b%b%b want 111", y2, y3, y4);
    end
    checks++;
    if ({b2, b3, b4} !== 9'd0) begin
      errors++; $display("FAIL idle_state: got %0d %0d %0d want 0 0 0", b2, b3, b4);
    end
  endtask

  task automatic test_fwd_wrap();
    int exp_g[5] = '{0, 1, 3, 2, 0};
    int exp_y[5] = '{0, 0, 1, 1, 0};
    int exp_t[5] = '{0, 0, 0, 0, 1};
    idle_all();
    th2 = 2;
    do_reset();
    en2 = 1; c2 = 1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (g2 !== 2'(exp_g[i]) || y2 !== 1'(exp_y[i]) || tc2 !== 1'(exp_t[i])) begin
        errors++;
        $display("FAIL fwd_wrap[%0d]: got g=%b y=%b tc=%b want g=%b y=%0d tc=%0d",
                 i, g2, y2, tc2, 2'(exp_g[i]), exp_y[i], exp_t[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_rev_wrap();
    int exp_g[5] = '{0, 2, 3, 1, 0};
    int exp_b[5] = '{0, 3, 2, 1, 0};
    int exp_y[5] = '{0, 1, 1, 0, 0};
    int exp_t[5] = '{0, 1, 0, 0, 0};
    idle_all();
    th2 = 2;
    do_reset();
    en2 = 1; c2 = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (g2 !== 2'(exp_g[i]) || b2 !== 2'(exp_b[i]) || y2 !== 1'(exp_y[i]) ||
          tc2 !== 1'(exp_t[i])) begin
        errors++;
        $display("FAIL rev_wrap[%0d]: got g=%b b=%0d y=%b tc=%b want g=%b b=%0d y=%0d tc=%0d",
                 i, g2, b2, y2, tc2, 2'(exp_g[i]), exp_b[i], exp_y[i], exp_t[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_saturate();
    idle_all();
    do_reset();
    en3 = 1; c3 = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (b3 !== 3'((i > 7) ? 7 : i) || tc3 !== ((i > 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL saturate[%0d]: got b=%0d tc=%b want b=%0d tc=%0d",
                 i, b3, tc3, (i > 7) ? 7 : i, (i > 7) ? 1 : 0);
      end
    end
    c3 = 0;
    tick();
    checks++;
    if (b3 !== 3'd6 || tc3 !== 1'b0 || g3 !== 3'b101) begin
      errors++; $display("FAIL sat_reverse: got b=%0d g=%b tc=%b want b=6 g=101 tc=0", b3, g3, tc3);
    end
    en3 = 0;
  endtask

  task automatic test_clr_priority();
    idle_all();
    th4 = 15;
    do_reset();
    en4 = 1; c4 = 1;
    repeat (9) tick();
    checks++;
    if (b4 !== 4'd9) begin
      errors++; $display("FAIL clr_setup: got b=%0d want 9", b4);
    end
    clr4 = 1; th4 = 0;
    tick();
    checks++;
    if (b4 !== 4'd0 || g4 !== 4'd0 || tc4 !== 1'b0 || y4 !== 1'b1) begin
      errors++; $display("FAIL clr_en: got b=%0d g=%b tc=%b y=%b want b=0 g=0000 tc=0 y=1", b4, g4, tc4, y4);
    end
    clr4 = 0;
    en2 = 1; c2 = 1;
    repeat (3) tick();
    checks++;
    if (b2 !== 2'd3) begin
      errors++; $display("FAIL clr_max_setup: got b=%0d want 3", b2);
    end
    clr2 = 1;
    tick();
    checks++;
    if (b2 !== 2'd0 || tc2 !== 1'b0) begin
      errors++; $display("FAIL clr_at_max: got b=%0d tc=%b want b=0 tc=0", b2, tc2);
    end
    idle_all();
  endtask

  task automatic test_thresh_hold();
    idle_all();
    th4 = 6;
    do_reset();
    en4 = 1; c4 = 1;
    repeat (5) tick();
    en4 = 0;
    tick();
    checks++;
    if (b4 !== 4'd5 || y4 !== 1'b0) begin
      errors++; $display("FAIL thresh_before: got b=%0d y=%b want b=5 y=0", b4, y4);
    end
    th4 = 5;
    #2;
    checks++;
    if (y4 !== 1'b0) begin
      errors++; $display("FAIL thresh_comb: got y=%b want 0 before clock", y4);
    end
    tick();
    checks++;
    if (b4 !== 4'd5 || y4 !== 1'b1) begin
      errors++; $display("FAIL thresh_after: got b=%0d y=%b want b=5 y=1", b4, y4);
    end
  endtask

  task automatic test_async_reset();
    idle_all();
    th4 = 3;
    do_reset();
    en4 = 1; c4 = 1;
    repeat (12) tick();
    checks++;
    if (b4 !== 4'd12 || y4 !== 1'b1) begin
      errors++; $display("FAIL async_setup: got b=%0d y=%b want b=12 y=1", b4, y4);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({g4, b4, y4, tc4} !== 10'd0) begin
      errors++; $display("FAIL async_reset: got g=%b b=%0d y=%b tc=%b want all 0", g4, b4, y4, tc4);
    end
    #2;
    rst = 0;
    tick();
    checks++;
    if (b4 !== 4'd1 || g4 !== 4'b0001) begin
      errors++; $display("FAIL async_resume: got b=%0d g=%b want b=1 g=0001", b4, g4);
    end
  endtask

  task automatic test_random();
    int s2, s3, s4, n2, n3, n4, t2, t3, t4, pg;
    idle_all();
    do_reset();
    s2 = 0; s3 = 0; s4 = 0;
    for (int k = 0; k < 400; k++) begin
      en2 = ($urandom_range(0, 3) != 0); clr2 = ($urandom_range(0, 9) == 0);
      c2 = 1'($urandom_range(0, 1));     th2 = 2'($urandom_range(0, 3));
      en3 = ($urandom_range(0, 3) != 0); clr3 = ($urandom_range(0, 9) == 0);
      c3 = ($urandom_range(0, 3) != 0);  th3 = 3'($urandom_range(0, 7));
      en4 = ($urandom_range(0, 3) != 0); clr4 = ($urandom_range(0, 15) == 0);
      c4 = 1'($urandom_range(0, 1));     th4 = 4'($urandom_range(0, 15));
      ref_step(2, 1, s2, int'(en2), int'(clr2), int'(c2), n2, t2);
      ref_step(3, 0, s3, int'(en3), int'(clr3), int'(c3), n3, t3);
      ref_step(4, 1, s4, int'(en4), int'(clr4), int'(c4), n4, t4);
      pg = int'(g4);
      tick();
      checks++;
      if (int'(b2) != n2 || int'(g2) != (n2 ^ (n2 >> 1)) || y2 !== (n2 >= int'(th2)) ||
          int'(tc2) != t2) begin
        errors++; $display("FAIL rand_w2[%0d]: got b=%0d g=%b y=%b tc=%b want b=%0d tc=%0d",
                           k, b2, g2, y2, tc2, n2, t2);
      end
      checks++;
      if (int'(b3) != n3 || int'(g3) != (n3 ^ (n3 >> 1)) || y3 !== (n3 >= int'(th3)) ||
          int'(tc3) != t3) begin
        errors++; $display("FAIL rand_w3[%0d]: got b=%0d g=%b y=%b tc=%b want b=%0d tc=%0d",
                           k, b3, g3, y3, tc3, n3, t3);
      end
      checks++;
      if (int'(b4) != n4 || int'(gray2bin(16'(g4))) != n4 || y4 !== (n4 >= int'(th4)) ||
          int'(tc4) != t4) begin
        errors++; $display("FAIL rand_w4[%0d]: got b=%0d g=%b y=%b tc=%b want b=%0d tc=%0d",
                           k, b4, g4, y4, tc4, n4, t4);
      end
      if (en4 && !clr4) begin
        checks++;
        if ($countones(pg ^ int'(g4)) != 1) begin
          errors++; $display("FAIL gray_1bit[%0d]: got %b -> %b want one bit change", k, 4'(pg), g4);
        end
      end
      s2 = n2; s3 = n3; s4 = n4;
    end
  endtask

  initial begin
    rst = 0;
    idle_all();
    test_reset();
    test_fwd_wrap();
    test_rev_wrap();
    test_saturate();
    test_clr_priority();
    test_thresh_hold();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
